// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame receiver: start bit, DATA_BITS data bits MSB-first, stop bit.
// Valid frames are queued in a small FIFO; drop and framing errors raise sticky flags.
module s2p_frame_ctrl #(
   parameter int DATA_BITS = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         bit_en,
   input  logic                         sdata,
   output logic [DATA_BITS-1:0]         m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [$clog2(BUF_DEPTH):0]   level,
   output logic                         busy,
   output logic                         overrun,
   output logic                         frame_err,
   input  logic                         err_clr
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      STOP  = 2'd2,
      BREAK = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   push_req;
   logic                   stop_err;

   logic [DATA_BITS-1:0]   mem [BUF_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [LVL_W-1:0]       level_reg;
   logic                   overrun_reg;
   logic                   frame_err_reg;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   push;
   logic                   drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         shift_reg <= shift_next;
      end
   end

   // The counter is cleared as the last data bit lands, so it is already 0
   // whenever DATA is entered and never moves outside DATA.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      shift_next = shift_reg;
      push_req   = 1'b0;
      stop_err   = 1'b0;
      if (bit_en) begin
         case (state_reg)
            IDLE: begin
               if (!sdata) begin
                  state_next = DATA;
                  cnt_next   = '0;
               end
            end
            DATA: begin
               shift_next = {shift_reg[DATA_BITS-2:0], sdata};
               if (cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                  cnt_next   = '0;
                  state_next = STOP;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            STOP: begin
               if (sdata) begin
                  push_req   = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_err   = 1'b1;
                  state_next = BREAK;
               end
            end
            BREAK: begin
               if (sdata) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);

   // A pop in the same cycle frees the slot, so a push into a full buffer still succeeds.
   assign full  = (level_reg == LVL_W'(BUF_DEPTH));
   assign empty = (level_reg == '0);
   assign pop   = !empty && m_ready;
   assign push  = push_req && (!full || pop);
   assign drop  = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= shift_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Error events take priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         if (drop) begin
            overrun_reg <= 1'b1;
         end else if (err_clr) begin
            overrun_reg <= 1'b0;
         end
         if (stop_err) begin
            frame_err_reg <= 1'b1;
         end else if (err_clr) begin
            frame_err_reg <= 1'b0;
         end
      end
   end

   assign m_data    = mem[rd_ptr_reg];
   assign m_valid   = !empty;
   assign level     = level_reg;
   assign overrun   = overrun_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: directed frames plus randomized traffic, all checked
// every cycle against a queue-based frame model.
module tb_s2p_frame_ctrl;

   localparam int DB = 8;
   localparam int BD = 2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 bit_en = 1'b0;
   logic                 sdata = 1'b1;
   logic                 m_ready = 1'b0;
   logic                 err_clr = 1'b0;
   logic [DB-1:0]        m_data;
   logic                 m_valid;
   logic [$clog2(BD):0]  level;
   logic                 busy;
   logic                 overrun;
   logic                 frame_err;

   s2p_frame_ctrl #(.DATA_BITS(DB), .BUF_DEPTH(BD)) dut (
      .clk(clk), .reset(reset), .bit_en(bit_en), .sdata(sdata),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
      .busy(busy), .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit rnd_ctrl = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: frame position (0 idle, 1 collecting, 2 awaiting stop, 3 line held low)
   int      mode = 0;
   int      nbits = 0;
   int      word = 0;
   int      q[$];
   bit      m_ovr = 0;
   bit      m_fe = 0;
   bit      started = 0;
   int      dut_out[$];

   always @(posedge clk) begin
      bit do_pop, do_push, set_ovr, set_fe;
      if (reset) begin
         mode = 0; nbits = 0; word = 0; q.delete(); m_ovr = 0; m_fe = 0; started = 1;
      end else if (started) begin
         do_pop = (q.size() > 0) && m_ready;
         do_push = 0; set_ovr = 0; set_fe = 0;
         if (bit_en) begin
            case (mode)
               0: if (!sdata) begin mode = 1; nbits = 0; word = 0; end
               1: begin
                  word = ((word << 1) | int'(sdata)) & ((1 << DB) - 1);
                  nbits++;
                  if (nbits == DB) mode = 2;
               end
               2: if (sdata) begin do_push = 1; mode = 0; end
                  else begin set_fe = 1; mode = 3; end
               default: if (sdata) mode = 0;
            endcase
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            if (q.size() < BD) q.push_back(word);
            else set_ovr = 1;
         end
         if (set_ovr) m_ovr = 1; else if (err_clr) m_ovr = 0;
         if (set_fe) m_fe = 1; else if (err_clr) m_fe = 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("level", level, q.size());
         chk("m_valid", m_valid, q.size() > 0);
         if (q.size() > 0) chk("m_data", m_data, q[0]);
         chk("busy", busy, mode != 0);
         chk("overrun", overrun, m_ovr);
         chk("frame_err", frame_err, m_fe);
         if (!reset && m_valid && m_ready) begin
            dut_out.push_back(int'(m_data));
            $display("pop data=%02h level=%0d", m_data, level);
         end
      end
   end

   task automatic cyc(bit en, bit d);
      @(posedge clk);
      #2;
      bit_en = en;
      sdata = d;
      if (rnd_ctrl) begin
         m_ready = ($urandom_range(0, 2) != 0);
         err_clr = ($urandom_range(0, 15) == 0);
      end
   endtask

   task automatic send_frame(int b, bit stop, int gap);
      cyc(1, 0);
      repeat (gap) cyc(0, 1'($urandom));
      for (int i = DB - 1; i >= 0; i--) begin
         cyc(1, b[i]);
         repeat (gap) cyc(0, 1'($urandom));
      end
      cyc(1, stop);
   endtask

   task automatic expect_out(string name, int exp[$]);
      chk({name, "_count"}, dut_out.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk(name, (i < dut_out.size()) ? dut_out[i] : 32'hFFFF_FFFF, exp[i]);
   endtask

   initial begin
      reset = 1;
      repeat (3) cyc(0, 1);
      reset = 0;
      #1;
      chk("rst_level", level, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {overrun, frame_err}, 0);

      // 0xA6 frame with consumer ready: valid for exactly one cycle
      m_ready = 1;
      dut_out.delete();
      send_frame(8'hA6, 1, 0);
      cyc(0, 1);
      #1;
      chk("a6_valid", m_valid, 1);
      chk("a6_level", level, 1);
      chk("a6_data", m_data, 8'hA6);
      cyc(0, 1);
      #1;
      chk("a6_valid_after", m_valid, 0);
      chk("a6_level_after", level, 0);
      expect_out("a6_out", '{8'hA6});

      // Three frames into a 2-deep buffer with no consumer
      m_ready = 0;
      send_frame(8'h11, 1, 0);
      send_frame(8'h22, 1, 1);
      send_frame(8'h33, 1, 0);
      cyc(0, 1);
      #1;
      chk("ovr_level", level, 2);
      chk("ovr_flag", overrun, 1);
      chk("ovr_model_level", q.size(), 2);
      dut_out.delete();
      m_ready = 1;
      repeat (4) cyc(0, 1);
      expect_out("ovr_drain", '{8'h11, 8'h22});
      err_clr = 1;
      cyc(0, 1);
      err_clr = 0;
      cyc(0, 1);
      #1;
      chk("ovr_clear", overrun, 0);

      // Bad stop bit, line held low, then released
      send_frame(8'h5A, 0, 0);
      cyc(1, 0);
      cyc(1, 0);
      #1;
      chk("fe_flag", frame_err, 1);
      chk("fe_busy_low", busy, 1);
      chk("fe_level", level, 0);
      cyc(1, 1);
      cyc(0, 1);
      #1;
      chk("fe_busy_released", busy, 0);
      err_clr = 1;
      cyc(0, 1);
      err_clr = 0;
      #1;
      chk("fe_clear", frame_err, 0);

      // Full buffer, third stop bit coincides with a pop
      m_ready = 0;
      dut_out.delete();
      send_frame(8'h11, 1, 0);
      send_frame(8'h22, 1, 0);
      send_frame(8'h33, 1, 0);
      m_ready = 1;
      cyc(0, 1);
      m_ready = 0;
      #1;
      chk("sim_level", level, 2);
      chk("sim_overrun", overrun, 0);
      m_ready = 1;
      repeat (4) cyc(0, 1);
      expect_out("sim_order", '{8'h11, 8'h22, 8'h33});

      // Reset in the middle of a frame, then a clean 0xC3 frame
      dut_out.delete();
      cyc(1, 0);
      cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 1);
      reset = 1;
      cyc(0, 1);
      reset = 0;
      send_frame(8'hC3, 1, 0);
      repeat (3) cyc(0, 1);
      #1;
      expect_out("rst_mid", '{8'hC3});
      chk("rst_mid_flags", {overrun, frame_err}, 0);

      // Line toggles with no bit strobes: nothing may move
      m_ready = 0;
      send_frame(8'h3C, 1, 0);
      cyc(1, 0);
      cyc(1, 1);
      repeat (40) cyc(0, 1'($urandom));
      #1;
      chk("idle_level", level, 1);
      chk("idle_data", m_data, 8'h3C);
      chk("idle_busy", busy, 1);
      m_ready = 1;
      cyc(0, 1);

      // Randomized traffic
      rnd_ctrl = 1;
      for (int k = 0; k < 250; k++) begin
         case ($urandom_range(0, 19))
            0: begin reset = 1; cyc(0, 1); reset = 0; end
            1: repeat ($urandom_range(1, 6)) cyc(1'($urandom), 1'($urandom));
            default: send_frame(int'($urandom_range(0, 255)),
                                ($urandom_range(0, 7) != 0), $urandom_range(0, 2));
         endcase
         repeat ($urandom_range(0, 3)) cyc(0, 1'($urandom));
      end
      rnd_ctrl = 0;
      m_ready = 1;
      err_clr = 0;
      repeat (6) cyc(1, 1);
      #1;
      chk("final_level", level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
